ahb_burst_addr_gen: RTL and testbench

//  Downstream stage of the bus arbiter. Takes the granted master's address-phase signals
//  (addr/htrans/hburst/hmaster) and data, tracks burst progress, and regenerates each SEQ

---
 rtl/ahb_burst_addr_gen.sv | 138 +++++++++++++
 tb/tb_ahb_burst_addr_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_addr_gen.sv
// Registers the granted master's address phase toward the slave, regenerating SEQ beat addresses (INCR/WRAP).
// One-cycle latency; hready=0 freezes all state, and the three event pulses read 0 on stalled cycles.
module ahb_burst_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MST_W  = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hready,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        htrans_in,
  input  logic [2:0]        hburst_in,
  input  logic [MST_W-1:0]  hmaster_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [ADDR_W-1:0] slv_addr,
  output logic [1:0]        slv_trans,
  output logic [2:0]        slv_burst,
  output logic [MST_W-1:0]  slv_master,
  output logic [DATA_W-1:0] slv_wdata,
  output logic [4:0]        beat_cnt,
  output logic              burst_done,
  output logic              burst_early,
  output logic              addr_err
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BUSY} state_t;

  state_t state;

  // Length 0 marks the unbounded INCR burst.
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b)
      3'b000:        burst_len = 5'd1;
      3'b001:        burst_len = 5'd0;
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      default:       burst_len = 5'd16;
    endcase
  endfunction

  logic [4:0]        cur_len;
  logic              cur_fixed;
  logic              cur_wrap;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [4:0]        next_cnt;
  logic              incomplete;

  always_comb begin
    cur_len    = burst_len(slv_burst);
    cur_fixed  = (slv_burst != BU_INCR);
    cur_wrap   = (slv_burst[0] == 1'b0) && (slv_burst != BU_SINGLE);
    wrap_mask  = ADDR_W'(cur_len - 5'd1);
    incr_addr  = slv_addr + ADDR_W'(1);
    next_addr  = cur_wrap ? ((slv_addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
    next_cnt   = (beat_cnt == 5'd16) ? 5'd16 : beat_cnt + 5'd1;
    incomplete = cur_fixed && (beat_cnt < cur_len);
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state       <= S_IDLE;
      slv_addr    <= '0;
      slv_trans   <= TR_IDLE;
      slv_burst   <= '0;
      slv_master  <= '0;
      slv_wdata   <= '0;
      beat_cnt    <= '0;
      burst_done  <= 1'b0;
      burst_early <= 1'b0;
      addr_err    <= 1'b0;
    end else if (!hready) begin
      burst_done  <= 1'b0;
      burst_early <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      burst_done  <= 1'b0;
      burst_early <= 1'b0;
      addr_err    <= 1'b0;
      slv_wdata   <= wdata_in;
      // NONSEQ always opens a new burst, cutting short whatever was in flight.
      if (htrans_in == TR_NONSEQ) begin
        burst_early <= (state != S_IDLE) && incomplete;
        slv_addr    <= addr_in;
        slv_trans   <= TR_NONSEQ;
        slv_burst   <= hburst_in;
        slv_master  <= hmaster_in;
        beat_cnt    <= 5'd1;
        if (hburst_in == BU_SINGLE) begin
          burst_done <= 1'b1;
          state      <= S_IDLE;
        end else begin
          state      <= S_ACTIVE;
        end
      end else if (state == S_IDLE) begin
        slv_trans <= TR_IDLE;
        beat_cnt  <= 5'd0;
        addr_err  <= (htrans_in == TR_SEQ);
      end else begin
        case (htrans_in)
          TR_SEQ: begin
            slv_addr  <= next_addr;
            slv_trans <= TR_SEQ;
            addr_err  <= (addr_in != next_addr);
            beat_cnt  <= next_cnt;
            if (cur_fixed && (next_cnt == cur_len)) begin
              burst_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state      <= S_ACTIVE;
            end
          end
          TR_BUSY: begin
            slv_trans <= TR_BUSY;
            state     <= S_BUSY;
          end
          default: begin
            burst_early <= incomplete;
            slv_trans   <= TR_IDLE;
            beat_cnt    <= 5'd0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Directed bench for ahb_burst_addr_gen: a vector table plus a hand-written reset-mid-burst sequence.
module tb_ahb_burst_addr_gen;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'd0, INC = 3'd1, W4 = 3'd2, I4 = 3'd3, W8 = 3'd4, I8 = 3'd5, I16 = 3'd7;

  logic       hclk = 1'b0;
  logic       hreset, hready;
  logic [7:0] addr_in;
  logic [1:0] htrans_in;
  logic [2:0] hburst_in;
  logic [3:0] hmaster_in;
  logic [7:0] wdata_in;
  logic [7:0] slv_addr;
  logic [1:0] slv_trans;
  logic [2:0] slv_burst;
  logic [3:0] slv_master;
  logic [7:0] slv_wdata;
  logic [4:0] beat_cnt;
  logic       burst_done, burst_early, addr_err;

  always #5 hclk = ~hclk;

  ahb_burst_addr_gen #(.ADDR_W(8), .DATA_W(8), .MST_W(4)) dut (
    .hclk(hclk), .hreset(hreset), .hready(hready),
    .addr_in(addr_in), .htrans_in(htrans_in), .hburst_in(hburst_in),
    .hmaster_in(hmaster_in), .wdata_in(wdata_in),
    .slv_addr(slv_addr), .slv_trans(slv_trans), .slv_burst(slv_burst),
    .slv_master(slv_master), .slv_wdata(slv_wdata), .beat_cnt(beat_cnt),
    .burst_done(burst_done), .burst_early(burst_early), .addr_err(addr_err)
  );

  typedef struct {
    logic       rdy;
    logic [7:0] a;
    logic [1:0] t;
    logic [2:0] b;
    logic [3:0] m;
    logic [7:0] wd;
    logic [7:0] ea;
    logic [1:0] et;
    logic [2:0] eb;
    logic [3:0] em;
    logic [7:0] ewd;
    logic [4:0] ec;
    logic       ed, ee, er;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] model_wd = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic [7:0] a, input logic [1:0] t, input logic [2:0] b,
                     input logic [3:0] m, input logic [7:0] ea, input logic [1:0] et, input logic [2:0] eb,
                     input logic [3:0] em, input logic [4:0] ec, input logic ed, input logic ee,
                     input logic er);
    vec_t v;
    v.rdy = rdy; v.a = a; v.t = t; v.b = b; v.m = m;
    v.wd  = 8'(vecs.size() * 37 + 5);
    if (rdy) model_wd = v.wd;
    v.ewd = model_wd;
    v.ea = ea; v.et = et; v.eb = eb; v.em = em; v.ec = ec; v.ed = ed; v.ee = ee; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic drive_step(input logic rdy, input logic [7:0] a, input logic [1:0] t,
                            input logic [2:0] b, input logic [3:0] m, input logic [7:0] wd);
    hready = rdy; addr_in = a; htrans_in = t; hburst_in = b; hmaster_in = m; wdata_in = wd;
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " addr"}, 32'(slv_addr), 0);
    chk({tag, " trans"}, 32'(slv_trans), 0);
    chk({tag, " burst"}, 32'(slv_burst), 0);
    chk({tag, " master"}, 32'(slv_master), 0);
    chk({tag, " wdata"}, 32'(slv_wdata), 0);
    chk({tag, " cnt"}, 32'(beat_cnt), 0);
    chk({tag, " pulses"}, 32'({burst_done, burst_early, addr_err}), 0);
  endtask

  initial begin
    // WRAP4 from 0x0E
    add(1, 8'h0E, NS, W4, 1, 8'h0E, NS, W4, 1, 1, 0, 0, 0);
    add(1, 8'h0F, SQ, W4, 1, 8'h0F, SQ, W4, 1, 2, 0, 0, 0);
    add(1, 8'h0C, SQ, W4, 1, 8'h0C, SQ, W4, 1, 3, 0, 0, 0);
    add(1, 8'h0D, SQ, W4, 1, 8'h0D, SQ, W4, 1, 4, 1, 0, 0);
    // INCR8 from 0xFC, wrapping through 0x00
    add(1, 8'hFC, NS, I8, 2, 8'hFC, NS, I8, 2, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++)
      add(1, 8'(8'hFC + k), SQ, I8, 2, 8'(8'hFC + k), SQ, I8, 2, 5'(k + 1), (k == 7), 0, 0);
    // INCR4 0x20 with a 3-cycle stall and a BUSY
    add(1, 8'h20, NS, I4, 3, 8'h20, NS, I4, 3, 1, 0, 0, 0);
    add(1, 8'h21, SQ, I4, 3, 8'h21, SQ, I4, 3, 2, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 8'h22, SQ, I4, 3, 8'h21, SQ, I4, 3, 2, 0, 0, 0);
    add(1, 8'h22, BSY, I4, 3, 8'h21, BSY, I4, 3, 2, 0, 0, 0);
    add(1, 8'h22, SQ, I4, 3, 8'h22, SQ, I4, 3, 3, 0, 0, 0);
    add(1, 8'h23, SQ, I4, 3, 8'h23, SQ, I4, 3, 4, 1, 0, 0);
    // INCR16 0x40 cut by IDLE after 5 beats
    add(1, 8'h40, NS, I16, 4, 8'h40, NS, I16, 4, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add(1, 8'(8'h40 + k), SQ, I16, 4, 8'(8'h40 + k), SQ, I16, 4, 5'(k + 1), 0, 0, 0);
    add(1, 8'h00, IDL, I16, 4, 8'h44, IDL, I16, 4, 0, 0, 1, 0);
    add(1, 8'h00, IDL, SGL, 0, 8'h44, IDL, I16, 4, 0, 0, 0, 0);
    // INCR4 0x10 with a wrong SEQ address, then cut by a SINGLE NONSEQ, then a stray SEQ
    add(1, 8'h10, NS, I4, 5, 8'h10, NS, I4, 5, 1, 0, 0, 0);
    add(1, 8'h99, SQ, I4, 5, 8'h11, SQ, I4, 5, 2, 0, 0, 1);
    add(1, 8'h12, SQ, I4, 5, 8'h12, SQ, I4, 5, 3, 0, 0, 0);
    add(1, 8'h55, NS, SGL, 6, 8'h55, NS, SGL, 6, 1, 1, 1, 0);
    add(1, 8'h56, SQ, SGL, 6, 8'h55, IDL, SGL, 6, 0, 0, 0, 1);
    // 20-beat INCR, master input changes mid-burst
    add(1, 8'h80, NS, INC, 7, 8'h80, NS, INC, 7, 1, 0, 0, 0);
    for (int k = 1; k <= 19; k++)
      add(1, 8'(8'h80 + k), SQ, INC, 9, 8'(8'h80 + k), SQ, INC, 7, (k >= 15) ? 5'd16 : 5'(k + 1), 0, 0, 0);
    add(1, 8'h00, IDL, INC, 9, 8'h93, IDL, INC, 7, 0, 0, 0, 0);
    // WRAP8 from 0x3D
    add(1, 8'h3D, NS, W8, 8, 8'h3D, NS, W8, 8, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++)
      add(1, 8'h38 | 8'((8'h3D + k) & 7), SQ, W8, 8, 8'h38 | 8'((8'h3D + k) & 7), SQ, W8, 8,
          5'(k + 1), (k == 7), 0, 0);
    add(1, 8'h00, IDL, W8, 8, 8'h3C, IDL, W8, 8, 0, 0, 0, 0);

    hreset = 1'b0; hready = 1'b1; addr_in = '0; htrans_in = IDL; hburst_in = '0;
    hmaster_in = '0; wdata_in = '0;
    #1;
    chk_all_zero("reset");
    @(posedge hclk); @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;

    foreach (vecs[i]) begin
      drive_step(vecs[i].rdy, vecs[i].a, vecs[i].t, vecs[i].b, vecs[i].m, vecs[i].wd);
      chk($sformatf("v%0d addr", i), 32'(slv_addr), 32'(vecs[i].ea));
      chk($sformatf("v%0d trans", i), 32'(slv_trans), 32'(vecs[i].et));
      chk($sformatf("v%0d burst", i), 32'(slv_burst), 32'(vecs[i].eb));
      chk($sformatf("v%0d master", i), 32'(slv_master), 32'(vecs[i].em));
      chk($sformatf("v%0d wdata", i), 32'(slv_wdata), 32'(vecs[i].ewd));
      chk($sformatf("v%0d cnt", i), 32'(beat_cnt), 32'(vecs[i].ec));
      chk($sformatf("v%0d done", i), 32'(burst_done), 32'(vecs[i].ed));
      chk($sformatf("v%0d early", i), 32'(burst_early), 32'(vecs[i].ee));
      chk($sformatf("v%0d err", i), 32'(addr_err), 32'(vecs[i].er));
    end

    // Asynchronous reset in the middle of an INCR8 at beat 3
    drive_step(1, 8'h30, NS, I8, 2, 8'h11);
    drive_step(1, 8'h31, SQ, I8, 2, 8'h12);
    drive_step(1, 8'h32, SQ, I8, 2, 8'h13);
    chk("mid addr", 32'(slv_addr), 32'h32);
    chk("mid cnt", 32'(beat_cnt), 3);
    #2;
    hreset = 1'b0;
    #1;
    chk_all_zero("async rst");
    #2;
    hreset = 1'b1;
    drive_step(1, 8'h60, NS, I8, 2, 8'h21);
    chk("post rst addr", 32'(slv_addr), 32'h60);
    chk("post rst trans", 32'(slv_trans), 32'(NS));
    chk("post rst cnt", 32'(beat_cnt), 1);
    drive_step(1, 8'h61, SQ, I8, 2, 8'h22);
    chk("post rst seq addr", 32'(slv_addr), 32'h61);
    chk("post rst seq cnt", 32'(beat_cnt), 2);
    chk("post rst err", 32'(addr_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
